// File: rtl/buffer_address_bind.sv
// buffer_address_bind
//
// Binds a pre-allocated buffer ID to every packet on the host-receive path.
// Free IDs from the allocator are queued in a small FIFO. Each packet takes
// one ID when its first word arrives. If no ID is available at that point,
// the whole packet is discarded. Forwarded words leave one cycle later, with
// the bound ID attached.
//
// Optional feature: define BUFFER_ADDRESS_BIND_STATS_EN to build the three
// saturating statistics counters. When it is not defined, the counter
// outputs are tied to zero and forwarding behaves the same.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   iv_data/i_data_wr  incoming packet word (MSB = EOP) and its valid
//   iv_bufid/i_bufid_wr free buffer ID from the allocator and its valid
//   o_bufid_full       ID FIFO full (registered)
//   ov_data/o_data_wr  forwarded word and its valid
//   ov_bufid           ID bound to the current packet, valid with o_data_wr
//   o_pkt_sop          first forwarded word of a packet
//   ov_pass_cnt        packets forwarded
//   ov_discard_cnt     packets discarded
//   ov_bufid_drop_cnt  IDs offered while the FIFO was full
module buffer_address_bind #(
  parameter int DATA_W     = 9,
  parameter int BUFID_W    = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DATA_W-1:0]  iv_data,
  input  logic               i_data_wr,
  input  logic [BUFID_W-1:0] iv_bufid,
  input  logic               i_bufid_wr,
  output logic               o_bufid_full,
  output logic [DATA_W-1:0]  ov_data,
  output logic               o_data_wr,
  output logic [BUFID_W-1:0] ov_bufid,
  output logic               o_pkt_sop,
  output logic [CNT_W-1:0]   ov_pass_cnt,
  output logic [CNT_W-1:0]   ov_discard_cnt,
  output logic [CNT_W-1:0]   ov_bufid_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [BUFID_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     fifo_cnt;
  logic [PTR_W:0]     fifo_cnt_next;
  logic [BUFID_W-1:0] held_id;

  logic               eop;
  logic               fifo_empty;
  logic               fifo_full_now;
  logic               sop_try;
  logic               pop;
  logic               bypass;
  logic               push;
  logic [BUFID_W-1:0] bound_id;

  // An ID is taken only by a word that arrives in IDLE. If the FIFO is
  // empty, an ID offered in the same cycle binds directly and is never
  // stored. A push into a full FIFO is accepted only when a pop frees a
  // slot in the same cycle.
  always_comb begin
    eop           = iv_data[DATA_W-1];
    fifo_empty    = (fifo_cnt == '0);
    fifo_full_now = (fifo_cnt == FULL_CNT);
    sop_try       = (state == IDLE) && i_data_wr;
    pop           = sop_try && !fifo_empty;
    bypass        = sop_try && fifo_empty && i_bufid_wr;
    push          = i_bufid_wr && !bypass && (!fifo_full_now || pop);
    bound_id      = bypass ? iv_bufid : fifo_mem[rd_ptr];
    fifo_cnt_next = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_next = fifo_cnt + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      fifo_cnt_next = fifo_cnt - (PTR_W+1)'(1);
    end
  end

  // ID storage has no reset. An entry is read only after it has been written.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= iv_bufid;
    end
  end

  // FIFO pointers, occupancy and the registered full flag. Depth is a power
  // of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_cnt     <= '0;
      o_bufid_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_cnt     <= fifo_cnt_next;
      o_bufid_full <= (fifo_cnt_next == FULL_CNT);
    end
  end

  // Packet FSM with registered outputs. Idle cycles drive every output to
  // zero. DROP stays in DROP until EOP, even if an ID arrives, so a packet
  // is never forwarded partially.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      held_id   <= '0;
      o_data_wr <= 1'b0;
      ov_data   <= '0;
      ov_bufid  <= '0;
      o_pkt_sop <= 1'b0;
    end else begin
      o_data_wr <= 1'b0;
      ov_data   <= '0;
      ov_bufid  <= '0;
      o_pkt_sop <= 1'b0;
      case (state)
        IDLE: begin
          if (i_data_wr) begin
            if (pop || bypass) begin
              o_data_wr <= 1'b1;
              ov_data   <= iv_data;
              ov_bufid  <= bound_id;
              o_pkt_sop <= 1'b1;
              held_id   <= bound_id;
              if (!eop) begin
                state <= XMIT;
              end
            end else if (!eop) begin
              state <= DROP;
            end
          end
        end
        XMIT: begin
          if (i_data_wr) begin
            o_data_wr <= 1'b1;
            ov_data   <= iv_data;
            ov_bufid  <= held_id;
            if (eop) begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (i_data_wr && eop) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BUFFER_ADDRESS_BIND_STATS_EN
  logic pass_evt;
  logic discard_evt;
  logic id_drop_evt;

  // A packet counts once, when its EOP word is seen. Whether it counts as
  // passed or discarded depends on whether it obtained an ID at SOP.
  always_comb begin
    pass_evt    = 1'b0;
    discard_evt = 1'b0;
    id_drop_evt = i_bufid_wr && !bypass && fifo_full_now && !pop;
    if (i_data_wr && eop) begin
      case (state)
        IDLE:    begin
          pass_evt    = pop || bypass;
          discard_evt = !(pop || bypass);
        end
        XMIT:    pass_evt    = 1'b1;
        DROP:    discard_evt = 1'b1;
        default: ;
      endcase
    end
  end

  // The statistics counters saturate at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_pass_cnt       <= '0;
      ov_discard_cnt    <= '0;
      ov_bufid_drop_cnt <= '0;
    end else begin
      if (pass_evt && (ov_pass_cnt != '1)) begin
        ov_pass_cnt <= ov_pass_cnt + CNT_W'(1);
      end
      if (discard_evt && (ov_discard_cnt != '1)) begin
        ov_discard_cnt <= ov_discard_cnt + CNT_W'(1);
      end
      if (id_drop_evt && (ov_bufid_drop_cnt != '1)) begin
        ov_bufid_drop_cnt <= ov_bufid_drop_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign ov_pass_cnt       = '0;
  assign ov_discard_cnt    = '0;
  assign ov_bufid_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_buffer_address_bind.sv
// Testbench for buffer_address_bind.
// The reference model works at packet level. It keeps a queue of free IDs,
// a mode (between packets / forwarding / discarding) and plain integer
// packet counts. Every cycle, the model predicts the registered outputs.
module tb_buffer_address_bind;

  localparam int DATA_W     = 9;
  localparam int BUFID_W    = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int CNT_CAP    = (1 << CNT_W) - 1;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [DATA_W-1:0]  iv_data;
  logic               i_data_wr;
  logic [BUFID_W-1:0] iv_bufid;
  logic               i_bufid_wr;
  logic               o_bufid_full;
  logic [DATA_W-1:0]  ov_data;
  logic               o_data_wr;
  logic [BUFID_W-1:0] ov_bufid;
  logic               o_pkt_sop;
  logic [CNT_W-1:0]   ov_pass_cnt;
  logic [CNT_W-1:0]   ov_discard_cnt;
  logic [CNT_W-1:0]   ov_bufid_drop_cnt;

  buffer_address_bind #(
    .DATA_W(DATA_W), .BUFID_W(BUFID_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .iv_data(iv_data), .i_data_wr(i_data_wr),
    .iv_bufid(iv_bufid), .i_bufid_wr(i_bufid_wr),
    .o_bufid_full(o_bufid_full),
    .ov_data(ov_data), .o_data_wr(o_data_wr),
    .ov_bufid(ov_bufid), .o_pkt_sop(o_pkt_sop),
    .ov_pass_cnt(ov_pass_cnt), .ov_discard_cnt(ov_discard_cnt),
    .ov_bufid_drop_cnt(ov_bufid_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int cmp_count = 0;
  int mis_count = 0;

  // Reference model state. mode: 0 = between packets, 1 = forwarding, 2 = discarding.
  int id_q[$];
  int mode;
  int held;
  int pass_m;
  int disc_m;
  int drop_m;

  logic               exp_wr;
  logic               exp_sop;
  logic [DATA_W-1:0]  exp_data;
  logic [BUFID_W-1:0] exp_bufid;
  logic               exp_full;

  function automatic logic [DATA_W-1:0] mkw(input bit e, input int v);
    return {e, (DATA_W-1)'(v)};
  endfunction

  function automatic logic [CNT_W-1:0] cntView(input int v);
`ifdef BUFFER_ADDRESS_BIND_STATS_EN
    return (v > CNT_CAP) ? CNT_W'(CNT_CAP) : CNT_W'(v);
`else
    return (v < 0) ? CNT_W'(1) : '0;
`endif
  endfunction

  task automatic modelReset();
    id_q.delete();
    mode = 0; held = 0; pass_m = 0; disc_m = 0; drop_m = 0;
    exp_wr = 0; exp_sop = 0; exp_data = '0; exp_bufid = '0; exp_full = 0;
  endtask

  task automatic modelStep(input logic dwr, input logic [DATA_W-1:0] d,
                           input logic bwr, input logic [BUFID_W-1:0] b);
    bit eop = d[DATA_W-1];
    bit direct = 0;
    bit got = 0;
    int id = 0;
    exp_wr = 0; exp_sop = 0; exp_data = '0; exp_bufid = '0;
    if (dwr) begin
      if (mode == 0) begin
        if (id_q.size() > 0) begin
          id = id_q.pop_front(); got = 1;
        end else if (bwr) begin
          id = int'(b); got = 1; direct = 1;
        end
        if (got) begin
          exp_wr = 1; exp_sop = 1; exp_data = d; exp_bufid = BUFID_W'(id);
          held = id;
          if (eop) pass_m++; else mode = 1;
        end else begin
          if (eop) disc_m++; else mode = 2;
        end
      end else if (mode == 1) begin
        exp_wr = 1; exp_data = d; exp_bufid = BUFID_W'(held);
        if (eop) begin pass_m++; mode = 0; end
      end else begin
        if (eop) begin disc_m++; mode = 0; end
      end
    end
    if (bwr && !direct) begin
      if (id_q.size() < FIFO_DEPTH) id_q.push_back(int'(b));
      else drop_m++;
    end
    exp_full = (id_q.size() == FIFO_DEPTH);
  endtask

  task automatic checkOne(input string tag, input string what,
                          input logic [31:0] obs, input logic [31:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      mis_count++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne(tag, "data_wr",   32'(o_data_wr),         32'(exp_wr));
    checkOne(tag, "data",      32'(ov_data),           32'(exp_data));
    checkOne(tag, "bufid",     32'(ov_bufid),          32'(exp_bufid));
    checkOne(tag, "sop",       32'(o_pkt_sop),         32'(exp_sop));
    checkOne(tag, "full",      32'(o_bufid_full),      32'(exp_full));
    checkOne(tag, "pass_cnt",  32'(ov_pass_cnt),       32'(cntView(pass_m)));
    checkOne(tag, "disc_cnt",  32'(ov_discard_cnt),    32'(cntView(disc_m)));
    checkOne(tag, "drop_cnt",  32'(ov_bufid_drop_cnt), 32'(cntView(drop_m)));
  endtask

  task automatic applyStimulus(input string tag, input logic dwr, input logic [DATA_W-1:0] d,
                               input logic bwr, input logic [BUFID_W-1:0] b);
    i_data_wr = dwr; iv_data = d; i_bufid_wr = bwr; iv_bufid = b;
    modelStep(dwr, d, bwr, b);
    @(posedge i_clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset(input string tag);
    i_rst = 1; i_data_wr = 0; iv_data = '0; i_bufid_wr = 0; iv_bufid = '0;
    modelReset();
    @(posedge i_clk);
    #1;
    checkOutput(tag);
    i_rst = 0;
  endtask

  initial begin
    i_rst = 1; i_data_wr = 0; iv_data = '0; i_bufid_wr = 0; iv_bufid = '0;
    modelReset();
    repeat (2) @(posedge i_clk);
    #1;
    applyReset("reset");

    // One ID, then a 4-word packet
    applyStimulus("t1_push", 0, '0, 1, 9'h005);
    applyStimulus("t1_w1", 1, mkw(0, 8'h11), 0, '0);
    applyStimulus("t1_w2", 1, mkw(0, 8'h22), 0, '0);
    applyStimulus("t1_w3", 1, mkw(0, 8'h33), 0, '0);
    applyStimulus("t1_w4", 1, mkw(1, 8'h44), 0, '0);
    applyStimulus("t1_idle", 0, '0, 0, '0);

    // Packet without an ID is dropped; an ID arriving mid-packet is queued
    applyStimulus("t2_w1", 1, mkw(0, 8'h51), 0, '0);
    applyStimulus("t2_w2", 1, mkw(0, 8'h52), 1, 9'h00A);
    applyStimulus("t2_w3", 1, mkw(1, 8'h53), 0, '0);
    applyStimulus("t2_next", 1, mkw(1, 8'h54), 0, '0);
    applyStimulus("t2_idle", 0, '0, 0, '0);

    // Bypass: ID offered on the SOP cycle with an empty FIFO
    applyStimulus("t3_w1", 1, mkw(0, 8'h61), 1, 9'h1FF);
    applyStimulus("t3_w2", 1, mkw(1, 8'h62), 0, '0);
    applyStimulus("t3_noid", 1, mkw(1, 8'h63), 0, '0);

    // Fill the FIFO past capacity, then drain it in order
    for (int i = 1; i <= 5; i++) applyStimulus("t4_push", 0, '0, 1, BUFID_W'(i));
    for (int i = 0; i < 4; i++) applyStimulus("t4_pkt", 1, mkw(1, 8'h70 + i), 0, '0);
    applyStimulus("t4_idle", 0, '0, 0, '0);

    // Back-to-back packets with a gap inside the first one
    applyStimulus("t5_push7", 0, '0, 1, 9'h007);
    applyStimulus("t5_push8", 0, '0, 1, 9'h008);
    applyStimulus("t5_p1w1", 1, mkw(0, 8'h81), 0, '0);
    applyStimulus("t5_gap", 0, '0, 0, '0);
    applyStimulus("t5_p1w2", 1, mkw(1, 8'h82), 0, '0);
    applyStimulus("t5_p2w1", 1, mkw(0, 8'h83), 0, '0);
    applyStimulus("t5_p2w2", 1, mkw(1, 8'h84), 0, '0);

    // Reset in the middle of a forwarded packet with IDs still queued
    applyStimulus("t6_push", 0, '0, 1, 9'h021);
    applyStimulus("t6_push", 0, '0, 1, 9'h022);
    applyStimulus("t6_push", 0, '0, 1, 9'h023);
    applyStimulus("t6_w1", 1, mkw(0, 8'h91), 0, '0);
    applyStimulus("t6_w2", 1, mkw(0, 8'h92), 0, '0);
    applyReset("t6_reset");
    applyStimulus("t6_after", 1, mkw(1, 8'h93), 0, '0);
    applyStimulus("t6_idle", 0, '0, 0, '0);

    // Randomized traffic mixed with ID pushes and occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic dwr, bwr, e;
      dwr = ($urandom_range(0, 9) < 6);
      e   = ($urandom_range(0, 3) == 0);
      bwr = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 299) == 0) begin
        applyReset("rnd_reset");
      end else begin
        applyStimulus("rnd", dwr, mkw(e, int'($urandom_range(0, 255))),
                      bwr, BUFID_W'($urandom_range(0, 511)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
